// File: rtl/wb_mem_arbiter_if.sv
// Bundle of the two requester ports (imem/dmem) and the shared core Wishbone bus.
// slave = arbiter side, master = requesters plus bus slave (environment) side.
interface wb_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                  imem_cyc_i;
    logic                  imem_we_i;
    logic [3:0]            imem_wstrb_i;
    logic [ADDR_WIDTH-1:0] imem_addr_i;
    logic [31:0]           imem_data_i;
    logic [31:0]           imem_data_o;
    logic                  imem_ack_o;
    logic                  imem_err_o;

    logic                  dmem_cyc_i;
    logic                  dmem_we_i;
    logic [3:0]            dmem_wstrb_i;
    logic [ADDR_WIDTH-1:0] dmem_addr_i;
    logic [31:0]           dmem_data_i;
    logic [31:0]           dmem_data_o;
    logic                  dmem_ack_o;
    logic                  dmem_err_o;

    logic                  core_cyc;
    logic                  core_stb;
    logic                  core_we;
    logic [3:0]            core_wstrb;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [31:0]           core_data_out;
    logic [31:0]           core_data_in;
    logic                  core_ack;

    modport slave (
        input  imem_cyc_i, imem_we_i, imem_wstrb_i, imem_addr_i, imem_data_i,
        output imem_data_o, imem_ack_o, imem_err_o,
        input  dmem_cyc_i, dmem_we_i, dmem_wstrb_i, dmem_addr_i, dmem_data_i,
        output dmem_data_o, dmem_ack_o, dmem_err_o,
        output core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out,
        input  core_data_in, core_ack
    );

    modport master (
        output imem_cyc_i, imem_we_i, imem_wstrb_i, imem_addr_i, imem_data_i,
        input  imem_data_o, imem_ack_o, imem_err_o,
        output dmem_cyc_i, dmem_we_i, dmem_wstrb_i, dmem_addr_i, dmem_data_i,
        input  dmem_data_o, dmem_ack_o, dmem_err_o,
        input  core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out,
        output core_data_in, core_ack
    );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-requester (imem/dmem) Wishbone arbiter onto one shared bus, with wait timeout.
// Define WB_MEM_ARBITER_ROUND_ROBIN_EN for round-robin on contention; default is dmem priority.
module wb_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input logic             clk_core,
    input logic             rst_core,
    wb_mem_arbiter_if.slave wb
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             gnt_cyc;
    logic             timeout_hit;
    logic             pick_d;

`ifdef WB_MEM_ARBITER_ROUND_ROBIN_EN
    logic last_d;  // 1 = last grant went to dmem

    always_comb pick_d = wb.dmem_cyc_i && (!wb.imem_cyc_i || !last_d);
`else
    always_comb pick_d = wb.dmem_cyc_i;
`endif

    // Granted requester's cyc and the timeout abort condition (ack wins over timeout)
    always_comb begin
        gnt_cyc = 1'b0;
        unique case (state)
            GNT_I:   gnt_cyc = wb.imem_cyc_i;
            GNT_D:   gnt_cyc = wb.dmem_cyc_i;
            default: gnt_cyc = 1'b0;
        endcase
        timeout_hit = (TIMEOUT_CYCLES != 0) && gnt_cyc && !wb.core_ack &&
                      (wait_cnt == CNT_LAST);
    end

    // Grant FSM and wait counter
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state    <= IDLE;
            wait_cnt <= '0;
`ifdef WB_MEM_ARBITER_ROUND_ROBIN_EN
            last_d   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (wb.imem_cyc_i || wb.dmem_cyc_i) begin
                        state    <= pick_d ? GNT_D : GNT_I;
                        wait_cnt <= '0;
`ifdef WB_MEM_ARBITER_ROUND_ROBIN_EN
                        last_d   <= pick_d;
`endif
                    end
                end
                default: begin
                    if (!gnt_cyc || wb.core_ack || timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Bus and requester muxing; everything is zero outside a grant
    always_comb begin
        wb.core_cyc      = 1'b0;
        wb.core_stb      = 1'b0;
        wb.core_we       = 1'b0;
        wb.core_wstrb    = 4'h0;
        wb.core_addr     = ADDR_WIDTH'(0);
        wb.core_data_out = 32'h0;
        wb.imem_data_o   = 32'h0;
        wb.imem_ack_o    = 1'b0;
        wb.imem_err_o    = 1'b0;
        wb.dmem_data_o   = 32'h0;
        wb.dmem_ack_o    = 1'b0;
        wb.dmem_err_o    = 1'b0;
        unique case (state)
            GNT_I: begin
                wb.core_cyc      = wb.imem_cyc_i && !timeout_hit;
                wb.core_stb      = wb.imem_cyc_i && !timeout_hit;
                wb.core_we       = wb.imem_we_i;
                wb.core_wstrb    = wb.imem_wstrb_i;
                wb.core_addr     = wb.imem_addr_i;
                wb.core_data_out = wb.imem_data_i;
                wb.imem_data_o   = wb.core_data_in;
                wb.imem_ack_o    = wb.imem_cyc_i && wb.core_ack;
                wb.imem_err_o    = timeout_hit;
            end
            GNT_D: begin
                wb.core_cyc      = wb.dmem_cyc_i && !timeout_hit;
                wb.core_stb      = wb.dmem_cyc_i && !timeout_hit;
                wb.core_we       = wb.dmem_we_i;
                wb.core_wstrb    = wb.dmem_wstrb_i;
                wb.core_addr     = wb.dmem_addr_i;
                wb.core_data_out = wb.dmem_data_i;
                wb.dmem_data_o   = wb.core_data_in;
                wb.dmem_ack_o    = wb.dmem_cyc_i && wb.core_ack;
                wb.dmem_err_o    = timeout_hit;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Scoreboard bench for wb_mem_arbiter (TIMEOUT_CYCLES=4); follows WB_MEM_ARBITER_ROUND_ROBIN_EN.
module tb_wb_mem_arbiter;
    typedef struct {
        logic        port_d;
        logic        is_err;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t q[$];

    wb_mem_arbiter_if #(.ADDR_WIDTH(32)) wb ();

    wb_mem_arbiter #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
        .clk_core (clk),
        .rst_core (rst),
        .wb       (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic port_d, input logic is_err, input logic [31:0] data);
        exp_t e;
        e.port_d = port_d;
        e.is_err = is_err;
        e.data   = data;
        q.push_back(e);
    endtask

    // Monitor: every ack/err the DUT presents must match the next expected response
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic        i_ev;
        logic        d_ev;
        logic        a_err;
        logic [31:0] a_data;
        i_ev = wb.imem_ack_o || wb.imem_err_o;
        d_ev = wb.dmem_ack_o || wb.dmem_err_o;
        if (i_ev || d_ev) begin
            total++;
            a_err  = d_ev ? wb.dmem_err_o : wb.imem_err_o;
            a_data = d_ev ? wb.dmem_data_o : wb.imem_data_o;
            if ((i_ev && d_ev) || (wb.imem_ack_o && wb.imem_err_o) ||
                (wb.dmem_ack_o && wb.dmem_err_o)) begin
                bad++;
                $display("FAIL sb_multi: got i_ack=%0b i_err=%0b d_ack=%0b d_err=%0b want one event at %0t",
                         wb.imem_ack_o, wb.imem_err_o, wb.dmem_ack_o, wb.dmem_err_o, $time);
            end else if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got port_d=%0b err=%0b want no response at %0t",
                         d_ev, a_err, $time);
            end else begin
                e = q.pop_front();
                if (d_ev !== e.port_d || a_err !== e.is_err || a_data !== e.data) begin
                    bad++;
                    $display("FAIL sb_resp: got port_d=%0b err=%0b data=0x%08h want port_d=%0b err=%0b data=0x%08h at %0t",
                             d_ev, a_err, a_data, e.port_d, e.is_err, e.data, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] order;
`ifdef WB_MEM_ARBITER_ROUND_ROBIN_EN
        order = 4'b0101;  // bit k: grant k went to dmem -> D,I,D,I
`else
        order = 4'b1111;  // D,D,D,D while dmem keeps requesting
`endif
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        wb.imem_cyc_i = 1'b1; wb.imem_we_i = 1'b0; wb.imem_wstrb_i = 4'hF;
        wb.imem_addr_i = 32'h10; wb.imem_data_i = 32'h0;
        wb.dmem_cyc_i = 1'b1; wb.dmem_we_i = 1'b0; wb.dmem_wstrb_i = 4'hF;
        wb.dmem_addr_i = 32'h20; wb.dmem_data_i = 32'h0;
        wb.core_ack = 1'b1; wb.core_data_in = 32'h0BADF00D;

        // Reset with both requesting and a stray ack: all outputs quiet
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_core_cyc", 32'(wb.core_cyc), 32'd0);
        chk("rst_core_addr", wb.core_addr, 32'h0);
        chk("rst_imem_ack", 32'(wb.imem_ack_o), 32'd0);
        chk("rst_dmem_data", wb.dmem_data_o, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_idle_cyc", 32'(wb.core_cyc), 32'd0);

        // Contention from reset; slave acks every grant, ack in idle gaps ignored
        for (int k = 0; k < 4; k++) push(order[k], 1'b0, 32'h0BADF00D);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            chk("arb_addr", wb.core_addr, order[k] ? 32'h20 : 32'h10);
            step();
            @(negedge clk);
            chk("arb_gap_cyc", 32'(wb.core_cyc), 32'd0);
        end
        #1;
        wb.imem_cyc_i = 1'b0; wb.dmem_cyc_i = 1'b0; wb.core_ack = 1'b0;

        // imem read at 0x100, acked in the 2nd bus cycle
        step();
        wb.imem_cyc_i = 1'b1; wb.imem_addr_i = 32'h100; wb.core_data_in = 32'h0;
        @(negedge clk);
        chk("rd_pre_cyc", 32'(wb.core_cyc), 32'd0);
        step();
        @(negedge clk);
        chk("rd_cyc", 32'(wb.core_cyc), 32'd1);
        chk("rd_stb", 32'(wb.core_stb), 32'd1);
        chk("rd_addr", wb.core_addr, 32'h100);
        chk("rd_we", 32'(wb.core_we), 32'd0);
        step();
        wb.core_ack = 1'b1; wb.core_data_in = 32'hDEADBEEF;
        push(1'b0, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        chk("rd_dmem_data", wb.dmem_data_o, 32'h0);

        // dmem write next; its grant right after proves the FSM went back to IDLE
        step();
        wb.core_ack = 1'b0; wb.imem_cyc_i = 1'b0;
        wb.dmem_cyc_i = 1'b1; wb.dmem_we_i = 1'b1; wb.dmem_addr_i = 32'h2000;
        wb.dmem_data_i = 32'h12345678; wb.dmem_wstrb_i = 4'h3;
        @(negedge clk);
        chk("rd_post_cyc", 32'(wb.core_cyc), 32'd0);
        step();
        @(negedge clk);
        chk("wr_cyc", 32'(wb.core_cyc), 32'd1);
        chk("wr_we", 32'(wb.core_we), 32'd1);
        chk("wr_addr", wb.core_addr, 32'h2000);
        chk("wr_data", wb.core_data_out, 32'h12345678);
        chk("wr_wstrb", 32'(wb.core_wstrb), 32'h3);
        step();
        wb.core_ack = 1'b1; wb.core_data_in = 32'h00C0FFEE;
        push(1'b1, 1'b0, 32'h00C0FFEE);
        @(negedge clk);
        chk("wr_imem_ack", 32'(wb.imem_ack_o), 32'd0);
        step();
        wb.core_ack = 1'b0; wb.dmem_cyc_i = 1'b0; wb.dmem_we_i = 1'b0;
        wb.dmem_wstrb_i = 4'hF; wb.core_data_in = 32'h0;
        @(negedge clk);
        chk("wr_post_cyc", 32'(wb.core_cyc), 32'd0);

        // Timeout: no ack, err in 4th grant cycle with core_cyc dropped
        step();
        wb.dmem_cyc_i = 1'b1; wb.dmem_addr_i = 32'h3000;
        push(1'b1, 1'b1, 32'h0);
        @(negedge clk);
        for (int g = 1; g <= 4; g++) begin
            step();
            @(negedge clk);
            chk("to_cyc", 32'(wb.core_cyc), (g < 4) ? 32'd1 : 32'd0);
        end
        chk("to_err", 32'(wb.dmem_err_o), 32'd1);
        step();
        wb.dmem_cyc_i = 1'b0; wb.imem_cyc_i = 1'b1; wb.imem_addr_i = 32'h300;
        @(negedge clk);
        chk("to_idle_cyc", 32'(wb.core_cyc), 32'd0);
        step();
        wb.core_ack = 1'b1; wb.core_data_in = 32'hCAFE0001;
        push(1'b0, 1'b0, 32'hCAFE0001);
        @(negedge clk);
        chk("to_next_addr", wb.core_addr, 32'h300);
        step();
        wb.core_ack = 1'b0; wb.imem_cyc_i = 1'b0;
        @(negedge clk);

        // Reset mid-wait in GNT_I with dmem pending
        step();
        wb.imem_cyc_i = 1'b1; wb.imem_addr_i = 32'h500;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("mr_gnt_cyc", 32'(wb.core_cyc), 32'd1);
        step();
        wb.dmem_cyc_i = 1'b1; wb.dmem_addr_i = 32'h400;
        #1;
        chk("mr_wait_addr", wb.core_addr, 32'h500);
        rst = 1'b1;
        #1;
        chk("mr_async_cyc", 32'(wb.core_cyc), 32'd0);
        chk("mr_async_addr", wb.core_addr, 32'h0);
        wb.imem_cyc_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_rel_cyc", 32'(wb.core_cyc), 32'd0);
        step();
        @(negedge clk);
        chk("mr_first_cyc", 32'(wb.core_cyc), 32'd1);
        chk("mr_first_addr", wb.core_addr, 32'h400);
        step();
        wb.core_ack = 1'b1; wb.core_data_in = 32'h55AA55AA;
        push(1'b1, 1'b0, 32'h55AA55AA);
        @(negedge clk);
        step();
        wb.core_ack = 1'b0; wb.dmem_cyc_i = 1'b0;
        @(negedge clk);

        // imem abort after one grant cycle
        step();
        wb.imem_cyc_i = 1'b1; wb.imem_addr_i = 32'h600;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("ab_gnt_cyc", 32'(wb.core_cyc), 32'd1);
        step();
        wb.imem_cyc_i = 1'b0;
        @(negedge clk);
        chk("ab_drop_cyc", 32'(wb.core_cyc), 32'd0);
        step();
        wb.imem_cyc_i = 1'b1;
        @(negedge clk);
        chk("ab_idle_cyc", 32'(wb.core_cyc), 32'd0);
        step();
        wb.core_ack = 1'b1; wb.core_data_in = 32'h60606060;
        push(1'b0, 1'b0, 32'h60606060);
        @(negedge clk);
        chk("ab_regnt_addr", wb.core_addr, 32'h600);
        step();
        wb.core_ack = 1'b0; wb.imem_cyc_i = 1'b0;
        @(negedge clk);
        chk("ab_post_cyc", 32'(wb.core_cyc), 32'd0);

        step();
        @(negedge clk);
        chk("sb_left", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
